uart_rx: RTL and testbench

- Receive side of the team's 8N1 UART link; the counterpart of the UART transmitter.
- Samples the asynchronous serial line RX and reassembles one byte per frame: start bit, 8 data bits LSB first, 1 stop bit.
- Presents the byte with a ready flag, plus framing-error and overrun status, to the command/control logic.
- Default timing matches the transmitter: 5208 clocks per bit, which is 19200 baud at 100 MHz.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver with ready, framing-error and overrun status.
// Revision: 1.0
// ============================================================================
module uart_rx #(
  parameter int BAUD_CNT  = 5208,
  parameter int HALF_BAUD = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int               CNT_W     = $clog2(BAUD_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BAUD);
  // Reloading with BAUD_CNT-1 makes the zero-to-zero interval exactly BAUD_CNT.
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CNT - 1);
  localparam logic [3:0]       STOP_BIT  = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rdy_q, rdy_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;

  // Synchronizer preset high so that reset itself never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rdy_d         = rdy_q;
    framing_err_d = framing_err_q;
    overrun_d     = overrun_q;

    if (clr_rdy) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = RECV;
          baud_cnt_d = HALF_LOAD;
          bit_cnt_d  = 4'd0;
        end
      end
      RECV: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end else begin
          baud_cnt_d = FULL_LOAD;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (rx_s_q) begin
              state_d    = IDLE;
              baud_cnt_d = '0;
              bit_cnt_d  = 4'd0;
            end
          end else if (bit_cnt_q == STOP_BIT) begin
            // Completion overrides a coincident clr_rdy.
            state_d       = IDLE;
            baud_cnt_d    = '0;
            bit_cnt_d     = 4'd0;
            rx_data_d     = shift_q;
            framing_err_d = ~rx_s_q;
            overrun_d     = rdy_q & ~clr_rdy;
            rdy_d         = 1'b1;
          end else begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rdy_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rdy_q         <= rdy_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rdy         = rdy_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : randomized bench for uart_rx against a timestamp-based frame model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

  localparam int B = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, framing_err, overrun;

  int vec = 0;
  int mis = 0;
  bit rand_clr = 1'b0;

  uart_rx #(.BAUD_CNT(B), .HALF_BAUD(H)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic r, input logic f, input logic o);
    check(name, {21'd0, rx_data, rdy, framing_err, overrun}, {21'd0, d, r, f, o});
  endtask

  // Reference model: the line seen by the receiver is RX two clocks late; a
  // frame is timestamped at its falling edge and bit n is read H+1+n*B later.
  logic [2:0] hist = 3'b111;
  bit         m_busy = 1'b0;
  bit         m_done;
  int         m_cyc = 0, m_t0 = 0, m_k;
  logic [7:0] m_byte = 8'h00, m_data = 8'h00;
  logic       m_rdy = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hist = 3'b111; m_busy = 1'b0; m_data = 8'h00;
      m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_cyc = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (hist[2] && !hist[1]) begin
          m_busy = 1'b1;
          m_t0   = m_cyc;
        end
      end else begin
        m_k = m_cyc - (m_t0 + 1 + H);
        if (m_k >= 0 && m_k % B == 0) begin
          if (m_k / B == 0) begin
            if (hist[1]) m_busy = 1'b0;
          end else if (m_k / B == 9) begin
            m_done = 1'b1;
            m_busy = 1'b0;
          end else begin
            m_byte[m_k / B - 1] = hist[1];
          end
        end
      end
      if (m_done) begin
        m_ov   = m_rdy && !clr_rdy;
        m_rdy  = 1'b1;
        m_data = m_byte;
        m_fe   = !hist[1];
      end else if (clr_rdy) begin
        m_rdy = 1'b0;
        m_ov  = 1'b0;
      end
      hist = {hist[1:0], RX};
      m_cyc++;
    end
  end

  // Cycle-by-cycle comparison and rdy rising-edge log.
  logic       prev_rdy = 1'b0;
  int         rise_cnt = 0;
  logic [7:0] got_q[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("outputs_vs_model", {21'd0, rx_data, rdy, framing_err, overrun},
            {21'd0, m_data, m_rdy, m_fe, m_ov});
      if (rdy && !prev_rdy) begin
        rise_cnt++;
        got_q.push_back(rx_data);
      end
      prev_rdy = rdy;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  task automatic idle(input int n);
    RX = 1'b1;
    for (int j = 0; j < n; j++) begin
      clr_rdy = rand_clr && ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    clr_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int clr_bit, input int clr_j, input int abort_bit);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < B; j++) begin
        RX = bits[i];
        clr_rdy = (i == clr_bit && j == clr_j) || (rand_clr && ($urandom_range(0, 60) == 0));
        if (i == abort_bit && j == B / 2) begin
          #2 rst_n = 1'b0;
          #1;
          chk_out("async_reset_midframe", 8'h00, 1'b0, 1'b0, 1'b0);
          clr_rdy = 1'b0;
          RX = 1'b1;
          return;
        end
        @(negedge clk);
      end
    end
    RX = 1'b1;
    clr_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    int         g;

    repeat (20) @(negedge clk);
    chk_out("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2 * B);
    chk_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Single byte
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    chk_out("single_A5", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    chk_out("clr_after_A5", 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(B);

    // Back-to-back, clearing during each following start bit
    got_q.delete();
    rise_cnt = 0;
    send_frame(8'h00, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, 0, 0, -1);
    send_frame(8'h5A, 1'b1, 0, 0, -1);
    check("b2b_rise_count", rise_cnt, 3);
    check("b2b_byte0", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h00);
    check("b2b_byte1", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hFF);
    check("b2b_byte2", (got_q.size() > 2) ? got_q[2] : 8'hxx, 8'h5A);
    chk_out("b2b_final", 8'h5A, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // False start: a short low pulse that is gone by the mid-point sample
    RX = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(2 * B);
    chk_out("false_start", 8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    chk_out("after_false_start", 8'h3C, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    idle(B);

    // Framing error then overrun
    send_frame(8'h81, 1'b0, -1, -1, -1);
    idle(B);
    chk_out("framing_err_81", 8'h81, 1'b1, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, -1, -1, -1);
    chk_out("overrun_42", 8'h42, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    chk_out("clr_overrun", 8'h42, 1'b0, 1'b0, 1'b0);
    idle(B);

    // Clear coinciding with completion while a prior byte is pending
    send_frame(8'h11, 1'b1, -1, -1, -1);
    send_frame(8'h99, 1'b1, 9, H + 3, -1);
    chk_out("clr_on_completion", 8'h99, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Break: line held low for well over a frame
    RX = 1'b0;
    repeat (12 * B) @(negedge clk);
    chk_out("break_frame", 8'h00, 1'b1, 1'b1, 1'b0);
    idle(3 * B);
    chk_out("break_no_refire", 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of bit 4
    send_frame(8'h77, 1'b1, -1, -1, 4);
    repeat (5) @(negedge clk);
    chk_out("held_in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(10 * B);
    chk_out("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, -1, -1, -1);
    chk_out("after_reset_C3", 8'hC3, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Randomized traffic
    rand_clr = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 7) != 0), -1, -1, -1);
      if ($urandom_range(0, 4) == 0) begin
        g = $urandom_range(1, H - 2);
        RX = 1'b0;
        repeat (g) @(negedge clk);
        idle(B);
      end
      idle($urandom_range(0, 2 * B));
    end
    rand_clr = 1'b0;
    idle(2 * B);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
`default_nettype wire
